text_vram: RTL and testbench
============================

# text_vram

Character video memory for the 100 x 30 text display. Holds one byte per cell and serves the HDMI text pipeline's VRAM read port (`vram_valid`/`vram_row`/`vram_col` → `vram_byte`). It accepts character writes from the terminal logic in logical (screen-relative) coordinates and implements hardware scrolling: it owns `top_row` and blank-fills the recycled row. Sits directly upstream of `hdmi`.

## Interface

Parameters:
- `BLANK`, 8'h20: fill byte used by all clear operations.

Ports:
- `clk` in 1: pixel clock, the single clock of the block.
- `reset_low` in 1: asynchronous, active-low reset.
- `vram_valid` in 1: read enable from the display pipeline.
- `vram_row` in 5: physical row, 0..29.
- `vram_col` in 7: column, 0..99.
- `vram_byte` out 8: read data.
- `top_row` out 5: physical row displayed at screen top, 0..29.
- `wr_valid` in 1: write request.
- `wr_ready` out 1: write accept.
- `wr_row` in 5: logical row, 0 = screen top.
- `wr_col` in 7: column.
- `wr_byte` in 8: character to write.
- `scroll_valid` in 1: scroll-up-one-line request.
- `scroll_ready` out 1: scroll accept.
- `busy` out 1: a clear sequence is in progress.

## Operation

- Storage is 4096 x 8, addressed `{row[4:0], col[6:0]}`. Only rows 0..29 and cols 0..99 are used. It has one read port (display) and one write port (shared by writes and the clear engine).
- FSM states: CLEAR_ALL, CLEAR_ROW, IDLE.
  - **CLEAR_ALL**: entered on reset release. Writes `BLANK` to every cell, row-major, one cell per cycle, 3000 cycles. Counter: col 0..99, then wrap to 0 and row+1, ending at row 29 col 99. Then goes to IDLE.
  - **IDLE**: `wr_ready` = `scroll_ready` = 1, `busy` = 0.
  - **CLEAR_ROW**: writes `BLANK` to cols 0..99 of `clear_row`, 100 cycles. Then goes to IDLE.
- Write mapping:
  - Physical row = `top_row + wr_row`; subtract 30 if the sum is ≥ 30. Use 6-bit intermediate arithmetic.
  - A write is accepted on `wr_valid & wr_ready`.
  - If `wr_row ≥ 30` or `wr_col ≥ 100`, the write is accepted and discarded; memory is unchanged.
- Scroll:
  - Accepted on `scroll_valid & scroll_ready`.
  - On acceptance, `clear_row <= top_row` and `top_row <= (top_row == 29) ? 0 : top_row + 1`. The FSM then enters CLEAR_ROW.
  - The old top line becomes the new bottom line and is blanked.
- Simultaneous write and scroll in IDLE: both are accepted. The write uses the pre-scroll `top_row` and commits on that edge. The scroll takes effect from the next cycle.
- `wr_ready`, `scroll_ready` = 0 and `busy` = 1 in CLEAR_ALL and CLEAR_ROW. Requests are held off, never dropped.
- The read port is independent of the FSM and never stalls. Out-of-range read addresses return undefined data.

## Timing

- Reset values (asserted asynchronously):
  - `top_row` = 0, `vram_byte` = 0.
  - `wr_ready` = 0, `scroll_ready` = 0, `busy` = 1.
  - FSM = CLEAR_ALL, clear counters = 0.
- Read latency is 1 cycle: `vram_byte` is valid the cycle after `vram_valid` = 1. It holds its value while `vram_valid` = 0.
- Read-during-write to the same address returns the old byte. The new byte is visible to a read issued on the following cycle.
- After reset release, the first CLEAR_ALL write occurs on the first clock edge. `wr_ready` rises 3000 cycles after release.
- Scroll:
  - Accepted at edge N: `top_row` changes at N, `busy` = 1 from N.
  - Cells are blanked on edges N+1 … N+100.
  - `wr_ready` = 1 again after edge N+100.
- Reset asserted mid-clear: the FSM aborts immediately, `top_row` returns to 0, and CLEAR_ALL restarts from cell 0 on release.
- `top_row` updates on the acceptance edge. The downstream display samples it as it chooses; this block performs no frame synchronisation.

## Test plan

- **Reset clear**: release reset and wait for `busy` = 0 → exactly 3000 cycles. Read (0,0), (29,99), (15,50) → 8'h20 each, one cycle after `vram_valid`.
- **Write/readback**: in IDLE, write logical (3,7) = 8'h41 → a physical read of (3,7) the next cycle returns 8'h41. A same-cycle read of that address returns 8'h20.
- **Scroll mapping**: scroll once → `top_row` = 1, `busy` high for 100 cycles, physical row 0 is all 8'h20. Write logical (29,0) = 8'h5A → physical (0,0) = 8'h5A.
- **Wrap**: 30 scrolls → `top_row` returns to 0 after passing 29. With `top_row` = 29, a write to logical (1,5) lands at physical (0,5).
- **Simultaneous / hold-off**:
  - Same-cycle write (0,0) = 8'h42 and scroll at `top_row` = 0 → both accepted. Physical (0,0) ends as 8'h20, blanked by the scroll.
  - A write presented during CLEAR_ROW stays pending until `wr_ready` and then commits.
- **Out-of-range and reset**:
  - Writes to (30,0) and (0,100) are accepted with no memory change.
  - Asserting `reset_low` during a CLEAR_ROW → `top_row` = 0 immediately, and a full 3000-cycle clear follows.

Source files
------------

// File: rtl/text_vram.sv
// text_vram: character memory for the 100 x 30 text display.
// One display read port, one write port shared by terminal writes and the
// blank-fill engine. Owns top_row and implements hardware scroll-up.
module text_vram #(
  parameter logic [7:0] BLANK = 8'h20
) (
  input  logic       clk,
  input  logic       reset_low,
  input  logic       vram_valid,
  input  logic [4:0] vram_row,
  input  logic [6:0] vram_col,
  output logic [7:0] vram_byte,
  output logic [4:0] top_row,
  input  logic       wr_valid,
  output logic       wr_ready,
  input  logic [4:0] wr_row,
  input  logic [6:0] wr_col,
  input  logic [7:0] wr_byte,
  input  logic       scroll_valid,
  output logic       scroll_ready,
  output logic       busy
);

  localparam int unsigned ROW_W  = 5;
  localparam int unsigned COL_W  = 7;
  localparam int unsigned ADDR_W = ROW_W + COL_W;
  localparam int unsigned DEPTH  = 1 << ADDR_W;

  localparam logic [ROW_W-1:0] LAST_ROW = 5'd29;
  localparam logic [COL_W-1:0] LAST_COL = 7'd99;
  localparam logic [ROW_W:0]   NUM_ROWS = 6'd30;

  typedef enum logic [1:0] {
    CLEAR_ALL = 2'd0,
    CLEAR_ROW = 2'd1,
    IDLE      = 2'd2
  } state_t;

  state_t             state;
  state_t             state_nx;
  logic [ROW_W-1:0]   row_cnt;
  logic [ROW_W-1:0]   row_cnt_nx;
  logic [COL_W-1:0]   col_cnt;
  logic [COL_W-1:0]   col_cnt_nx;
  logic [ROW_W-1:0]   clear_row;
  logic [ROW_W-1:0]   clear_row_nx;
  logic [ROW_W-1:0]   top_row_nx;

  logic               mem_we;
  logic [ADDR_W-1:0]  mem_addr;
  logic [7:0]         mem_din;

  logic [ROW_W:0]     phys_raw;
  logic [ROW_W:0]     phys_wrap;
  logic [ROW_W-1:0]   phys_row;
  logic               wr_in_range;

  logic [7:0]         mem [DEPTH];

  // Map a logical (screen-relative) row onto the physical ring of rows.
  always_comb begin
    phys_raw    = 6'(top_row) + 6'(wr_row);
    phys_wrap   = (phys_raw >= NUM_ROWS) ? (phys_raw - NUM_ROWS) : phys_raw;
    phys_row    = 5'(phys_wrap);
    wr_in_range = (wr_row <= LAST_ROW) && (wr_col <= LAST_COL);
  end

  // Next-state, clear counters and write-port steering.
  always_comb begin
    state_nx     = state;
    row_cnt_nx   = row_cnt;
    col_cnt_nx   = col_cnt;
    clear_row_nx = clear_row;
    top_row_nx   = top_row;
    mem_we       = 1'b0;
    mem_addr     = '0;
    mem_din      = BLANK;

    case (state)
      CLEAR_ALL: begin
        mem_we   = 1'b1;
        mem_addr = {row_cnt, col_cnt};
        if (col_cnt == LAST_COL) begin
          col_cnt_nx = '0;
          if (row_cnt == LAST_ROW) begin
            row_cnt_nx = '0;
            state_nx   = IDLE;
          end else begin
            row_cnt_nx = row_cnt + 5'd1;
          end
        end else begin
          col_cnt_nx = col_cnt + 7'd1;
        end
      end

      CLEAR_ROW: begin
        mem_we   = 1'b1;
        mem_addr = {clear_row, col_cnt};
        if (col_cnt == LAST_COL) begin
          col_cnt_nx = '0;
          state_nx   = IDLE;
        end else begin
          col_cnt_nx = col_cnt + 7'd1;
        end
      end

      IDLE: begin
        // Write uses the pre-scroll top_row; out-of-range cells are dropped.
        if (wr_valid && wr_in_range) begin
          mem_we   = 1'b1;
          mem_addr = {phys_row, wr_col};
          mem_din  = wr_byte;
        end
        if (scroll_valid) begin
          clear_row_nx = top_row;
          top_row_nx   = (top_row == LAST_ROW) ? '0 : (top_row + 5'd1);
          col_cnt_nx   = '0;
          state_nx     = CLEAR_ROW;
        end
      end

      default: state_nx = CLEAR_ALL;
    endcase
  end

  // State, counters, top_row and registered handshake outputs.
  always_ff @(posedge clk or negedge reset_low) begin
    if (!reset_low) begin
      state        <= CLEAR_ALL;
      row_cnt      <= '0;
      col_cnt      <= '0;
      clear_row    <= '0;
      top_row      <= '0;
      wr_ready     <= 1'b0;
      scroll_ready <= 1'b0;
      busy         <= 1'b1;
    end else begin
      state        <= state_nx;
      row_cnt      <= row_cnt_nx;
      col_cnt      <= col_cnt_nx;
      clear_row    <= clear_row_nx;
      top_row      <= top_row_nx;
      wr_ready     <= (state_nx == IDLE);
      scroll_ready <= (state_nx == IDLE);
      busy         <= (state_nx != IDLE);
    end
  end

  // Storage write port.
  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem[mem_addr] <= mem_din;
    end
  end

  // Display read port: one-cycle latency, holds when not enabled.
  always_ff @(posedge clk or negedge reset_low) begin
    if (!reset_low) begin
      vram_byte <= '0;
    end else if (vram_valid) begin
      vram_byte <= mem[{vram_row, vram_col}];
    end
  end

endmodule

// File: tb/tb_text_vram.sv
// tb_text_vram: table vectors, directed scroll/reset sequences and random
// traffic, all checked against a cell-array reference model.
module tb_text_vram;

  logic       clk = 1'b0;
  logic       reset_low;
  logic       vram_valid;
  logic [4:0] vram_row;
  logic [6:0] vram_col;
  logic [7:0] vram_byte;
  logic [4:0] top_row;
  logic       wr_valid;
  logic       wr_ready;
  logic [4:0] wr_row;
  logic [6:0] wr_col;
  logic [7:0] wr_byte;
  logic       scroll_valid;
  logic       scroll_ready;
  logic       busy;

  int total = 0;
  int bad   = 0;

  // Reference model: screen cells, ring top, and remaining blank-fill cells.
  logic [7:0] m_mem [30][100];
  int         m_top;
  int         m_left;
  int         m_clear_row;
  bit         m_full;
  logic [7:0] m_byte;

  typedef struct {
    logic       vv;
    logic [4:0] vr;
    logic [6:0] vc;
    logic       wv;
    logic [4:0] wr;
    logic [6:0] wc;
    logic [7:0] wb;
    logic [7:0] exp;
  } vec_t;

  vec_t tbl [12];

  text_vram dut (
    .clk          (clk),
    .reset_low    (reset_low),
    .vram_valid   (vram_valid),
    .vram_row     (vram_row),
    .vram_col     (vram_col),
    .vram_byte    (vram_byte),
    .top_row      (top_row),
    .wr_valid     (wr_valid),
    .wr_ready     (wr_ready),
    .wr_row       (wr_row),
    .wr_col       (wr_col),
    .wr_byte      (wr_byte),
    .scroll_valid (scroll_valid),
    .scroll_ready (scroll_ready),
    .busy         (busy)
  );

  always #5 clk = ~clk;

  initial begin
    #5ms;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  task automatic model_reset();
    m_top  = 0;
    m_left = 3000;
    m_full = 1'b1;
    m_byte = 8'h00;
  endtask

  // Apply one cycle of inputs, advance the model, then compare all outputs.
  task automatic cyc(input logic vv, input logic [4:0] vr, input logic [6:0] vc,
                     input logic wv, input logic [4:0] wr, input logic [6:0] wc,
                     input logic [7:0] wb, input logic sv);
    int idx;
    vram_valid   = vv;
    vram_row     = vr;
    vram_col     = vc;
    wr_valid     = wv;
    wr_row       = wr;
    wr_col       = wc;
    wr_byte      = wb;
    scroll_valid = sv;
    @(posedge clk);
    if (vv) m_byte = m_mem[int'(vr)][int'(vc)];
    if (m_left > 0) begin
      idx = (m_full ? 3000 : 100) - m_left;
      if (m_full) m_mem[idx / 100][idx % 100] = 8'h20;
      else        m_mem[m_clear_row][idx]     = 8'h20;
      m_left--;
    end else begin
      if (wv && int'(wr) < 30 && int'(wc) < 100)
        m_mem[(m_top + int'(wr)) % 30][int'(wc)] = wb;
      if (sv) begin
        m_clear_row = m_top;
        m_top       = (m_top + 1) % 30;
        m_left      = 100;
        m_full      = 1'b0;
      end
    end
    #1;
    check("top_row",      32'(top_row),      32'(m_top));
    check("wr_ready",     32'(wr_ready),     32'(m_left == 0));
    check("scroll_ready", 32'(scroll_ready), 32'(m_left == 0));
    check("busy",         32'(busy),         32'(m_left != 0));
    check("vram_byte",    32'(vram_byte),    32'(m_byte));
  endtask

  task automatic idle();
    cyc(1'b0, 5'd0, 7'd0, 1'b0, 5'd0, 7'd0, 8'h00, 1'b0);
  endtask

  task automatic rd(input logic [4:0] r, input logic [6:0] c);
    cyc(1'b1, r, c, 1'b0, 5'd0, 7'd0, 8'h00, 1'b0);
  endtask

  task automatic wr(input logic [4:0] r, input logic [6:0] c, input logic [7:0] b);
    cyc(1'b0, 5'd0, 7'd0, 1'b1, r, c, b, 1'b0);
  endtask

  task automatic scroll();
    cyc(1'b0, 5'd0, 7'd0, 1'b0, 5'd0, 7'd0, 8'h00, 1'b1);
  endtask

  // Idle until wr_ready rises or the budget runs out; returns cycles spent.
  task automatic wait_ready(input int budget, output int n);
    n = 0;
    while (!wr_ready && n < budget) begin
      idle();
      n++;
    end
  endtask

  initial begin
    int n;
    int k;
    logic rb;

    for (int r = 0; r < 30; r++)
      for (int c = 0; c < 100; c++)
        m_mem[r][c] = 8'h00;

    reset_low    = 1'b0;
    vram_valid   = 1'b0;
    vram_row     = '0;
    vram_col     = '0;
    wr_valid     = 1'b0;
    wr_row       = '0;
    wr_col       = '0;
    wr_byte      = '0;
    scroll_valid = 1'b0;
    model_reset();

    repeat (3) @(posedge clk);
    #1;
    check("rst_top_row",      32'(top_row),      32'd0);
    check("rst_vram_byte",    32'(vram_byte),    32'd0);
    check("rst_wr_ready",     32'(wr_ready),     32'd0);
    check("rst_scroll_ready", 32'(scroll_ready), 32'd0);
    check("rst_busy",         32'(busy),         32'd1);

    // Power-up clear length.
    reset_low = 1'b1;
    wait_ready(4000, n);
    check("clear_all_cycles", 32'(n), 32'd3000);

    // Table vectors at top_row = 0, screen blank.
    tbl[0]  = '{1'b1, 5'd0,  7'd0,  1'b0, 5'd0,  7'd0,   8'h00, 8'h20};
    tbl[1]  = '{1'b1, 5'd29, 7'd99, 1'b0, 5'd0,  7'd0,   8'h00, 8'h20};
    tbl[2]  = '{1'b1, 5'd15, 7'd50, 1'b0, 5'd0,  7'd0,   8'h00, 8'h20};
    tbl[3]  = '{1'b1, 5'd3,  7'd7,  1'b1, 5'd3,  7'd7,   8'h41, 8'h20};
    tbl[4]  = '{1'b1, 5'd3,  7'd7,  1'b0, 5'd0,  7'd0,   8'h00, 8'h41};
    tbl[5]  = '{1'b1, 5'd0,  7'd0,  1'b1, 5'd30, 7'd0,   8'h77, 8'h20};
    tbl[6]  = '{1'b1, 5'd0,  7'd0,  1'b1, 5'd0,  7'd100, 8'h77, 8'h20};
    tbl[7]  = '{1'b0, 5'd0,  7'd0,  1'b0, 5'd0,  7'd0,   8'h00, 8'h20};
    tbl[8]  = '{1'b1, 5'd29, 7'd99, 1'b1, 5'd29, 7'd99,  8'h5b, 8'h20};
    tbl[9]  = '{1'b1, 5'd29, 7'd99, 1'b0, 5'd0,  7'd0,   8'h00, 8'h5b};
    tbl[10] = '{1'b0, 5'd0,  7'd0,  1'b1, 5'd0,  7'd0,   8'hc3, 8'h5b};
    tbl[11] = '{1'b1, 5'd0,  7'd0,  1'b0, 5'd0,  7'd0,   8'h00, 8'hc3};
    for (int i = 0; i < 12; i++) begin
      cyc(tbl[i].vv, tbl[i].vr, tbl[i].vc, tbl[i].wv, tbl[i].wr, tbl[i].wc, tbl[i].wb, 1'b0);
      check($sformatf("vec%0d_byte", i), 32'(vram_byte), 32'(tbl[i].exp));
    end

    // Single scroll: mapping and recycled row blanked.
    scroll();
    check("scroll_top", 32'(top_row), 32'd1);
    check("scroll_busy", 32'(busy), 32'd1);
    wait_ready(200, n);
    check("clear_row_cycles", 32'(n), 32'd100);
    for (int c = 0; c < 100; c++) begin
      rd(5'd0, 7'(c));
      check("row0_blank", 32'(vram_byte), 32'h20);
    end
    wr(5'd29, 7'd0, 8'h5a);
    rd(5'd0, 7'd0);
    check("scroll_map", 32'(vram_byte), 32'h5a);

    // Wrap: walk top_row to 29, write through the wrap, then back to 0.
    for (int i = 0; i < 28; i++) begin
      scroll();
      wait_ready(200, n);
    end
    check("top_29", 32'(top_row), 32'd29);
    wr(5'd1, 7'd5, 8'h99);
    rd(5'd0, 7'd5);
    check("wrap_map", 32'(vram_byte), 32'h99);
    scroll();
    check("top_wrap0", 32'(top_row), 32'd0);
    wait_ready(200, n);

    // Simultaneous write and scroll at top_row = 0: scroll blanks the write.
    cyc(1'b0, 5'd0, 7'd0, 1'b1, 5'd0, 7'd0, 8'h42, 1'b1);
    check("simul_top", 32'(top_row), 32'd1);
    check("simul_ready", 32'(wr_ready), 32'd0);
    wait_ready(200, n);
    rd(5'd0, 7'd0);
    check("simul_blank", 32'(vram_byte), 32'h20);

    // Write held off during a row clear, committed once ready.
    scroll();
    k = 0;
    rb = 1'b0;
    while (!rb && k < 200) begin
      rb = wr_ready;
      cyc(1'b0, 5'd0, 7'd0, 1'b1, 5'd2, 7'd3, 8'h66, 1'b0);
      k++;
    end
    check("holdoff_attempts", 32'(k), 32'd101);
    idle();
    rd(5'd4, 7'd3);
    check("holdoff_commit", 32'(vram_byte), 32'h66);

    // Reset in the middle of a row clear.
    scroll();
    check("pre_rst_top", 32'(top_row), 32'd3);
    repeat (10) idle();
    reset_low = 1'b0;
    #1;
    check("midrst_top", 32'(top_row), 32'd0);
    check("midrst_busy", 32'(busy), 32'd1);
    check("midrst_ready", 32'(wr_ready), 32'd0);
    model_reset();
    #1;
    reset_low = 1'b1;
    wait_ready(4000, n);
    check("reclear_cycles", 32'(n), 32'd3000);

    // Random traffic against the model.
    for (int i = 0; i < 3000; i++) begin
      cyc(1'($urandom_range(1)),
          5'($urandom_range(29)),
          7'($urandom_range(99)),
          1'($urandom_range(2) == 0),
          5'($urandom_range(31)),
          ($urandom_range(7) == 0) ? 7'(100 + $urandom_range(27)) : 7'($urandom_range(99)),
          8'($urandom),
          1'($urandom_range(49) == 0));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
